register_bank: RTL and testbench

- Architectural state holder at the far end of the writeback interface. Accepts register-write and PC-write requests from writeback and applies them on the next rising clock edge.
- Serves two combinational operand read ports to decode, holds and advances the fetch PC, and keeps a per-register pending scoreboard so decode can detect RAW hazards.
- Also counts retired writeback events.

---
 rtl/register_bank.sv | 82 ++++++++
 tb/tb_register_bank.sv | 136 +++++++++++++
 2 files changed

// File: rtl/register_bank.sv
// Architectural register file, fetch PC and RAW-hazard scoreboard at the writeback sink.
// Reads and redirect are combinational; all state updates land on the next rising edge.
module register_bank #(
  parameter int unsigned NREGS    = 16,
  parameter logic [19:0] PC_RESET = 20'h00000
) (
  input  logic        clk,
  input  logic        rst_sync,
  input  logic        write_en,
  input  logic [31:0] write,
  input  logic [3:0]  write_index,
  input  logic        write_pc_en,
  input  logic        pc_offset,
  input  logic [19:0] pc,
  input  logic        fetch_advance,
  input  logic [3:0]  rs1_index,
  output logic [31:0] rs1_data,
  input  logic [3:0]  rs2_index,
  output logic [31:0] rs2_data,
  input  logic        reserve_en,
  input  logic [3:0]  reserve_index,
  output logic        rs1_pending,
  output logic        rs2_pending,
  output logic [19:0] pc_out,
  output logic        redirect,
  output logic [31:0] retired
);

  logic [31:0]      regs [NREGS];
  logic [NREGS-1:0] pending;

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (write_en && write_index != 4'd0) begin
      regs[write_index] <= write;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_sync)
      pc_out <= PC_RESET;
    else if (write_pc_en)
      pc_out <= pc_offset ? pc_out + pc : pc;
    else if (fetch_advance)
      pc_out <= pc_out + 20'd1;
  end

  // The set is written after the clear so a same-index reserve overrides the retiring write.
  always_ff @(posedge clk) begin
    if (rst_sync || write_pc_en) begin
      pending <= '0;
    end else begin
      if (write_en) pending[write_index] <= 1'b0;
      if (reserve_en && reserve_index != 4'd0) pending[reserve_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_sync)
      retired <= '0;
    else if (write_en || write_pc_en)
      retired <= retired + 32'd1;
  end

  always_comb begin
    rs1_data = '0;
    if (rs1_index != 4'd0)
      rs1_data = (write_en && rs1_index == write_index) ? write : regs[rs1_index];
  end

  always_comb begin
    rs2_data = '0;
    if (rs2_index != 4'd0)
      rs2_data = (write_en && rs2_index == write_index) ? write : regs[rs2_index];
  end

  assign rs1_pending = pending[rs1_index];
  assign rs2_pending = pending[rs2_index];
  assign redirect    = write_pc_en;

endmodule

// File: tb/tb_register_bank.sv
// Directed, table-driven bench for register_bank.
module tb_register_bank;

  logic        clk = 1'b0;
  logic        rst_sync, write_en, write_pc_en, pc_offset, fetch_advance, reserve_en;
  logic [31:0] write;
  logic [3:0]  write_index, rs1_index, rs2_index, reserve_index;
  logic [19:0] pc;
  logic [31:0] rs1_data, rs2_data, retired;
  logic        rs1_pending, rs2_pending, redirect;
  logic [19:0] pc_out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  register_bank #(.NREGS(16), .PC_RESET(20'h00000)) dut (
    .clk(clk), .rst_sync(rst_sync),
    .write_en(write_en), .write(write), .write_index(write_index),
    .write_pc_en(write_pc_en), .pc_offset(pc_offset), .pc(pc),
    .fetch_advance(fetch_advance),
    .rs1_index(rs1_index), .rs1_data(rs1_data),
    .rs2_index(rs2_index), .rs2_data(rs2_data),
    .reserve_en(reserve_en), .reserve_index(reserve_index),
    .rs1_pending(rs1_pending), .rs2_pending(rs2_pending),
    .pc_out(pc_out), .redirect(redirect), .retired(retired)
  );

  typedef struct {
    logic        rst, we;
    logic [31:0] wd;
    logic [3:0]  wi;
    logic        pwe, poff;
    logic [19:0] pcv;
    logic        fa;
    logic [3:0]  r1, r2;
    logic        re;
    logic [3:0]  ri;
    // expected: combinational before the edge, then state after it
    logic [31:0] e_r1d, e_r2d;
    logic        e_r1p, e_r2p, e_rd;
    logic [19:0] e_pc;
    logic [31:0] e_ret;
  } vec_t;

  localparam int NV = 27;
  vec_t tv [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    rst_sync = 1'b0; write_en = 1'b0; write = '0; write_index = '0;
    write_pc_en = 1'b0; pc_offset = 1'b0; pc = '0; fetch_advance = 1'b0;
    rs1_index = '0; rs2_index = '0; reserve_en = 1'b0; reserve_index = '0;
  endtask

  initial begin
    //        rst   we    wd             wi     pwe   poff  pcv        fa    r1     r2     re    ri      r1d            r2d            r1p   r2p   rd    pc         ret
    tv[0]  = '{1'b0,1'b0,32'h0,         4'd0, 1'b0,1'b0,20'h0,     1'b1,4'd0, 4'd0, 1'b0,4'd0,  32'h0,         32'h0,         1'b0,1'b0,1'b0,20'h00001,32'd0};
    tv[1]  = '{1'b0,1'b0,32'h0,         4'd0, 1'b0,1'b0,20'h0,     1'b1,4'd0, 4'd0, 1'b0,4'd0,  32'h0,         32'h0,         1'b0,1'b0,1'b0,20'h00002,32'd0};
    tv[2]  = '{1'b0,1'b0,32'h0,         4'd0, 1'b0,1'b0,20'h0,     1'b1,4'd0, 4'd0, 1'b0,4'd0,  32'h0,         32'h0,         1'b0,1'b0,1'b0,20'h00003,32'd0};
    tv[3]  = '{1'b0,1'b1,32'hDEADBEEF,  4'd5, 1'b0,1'b0,20'h0,     1'b0,4'd5, 4'd0, 1'b0,4'd0,  32'hDEADBEEF,  32'h0,         1'b0,1'b0,1'b0,20'h00003,32'd1};
    tv[4]  = '{1'b0,1'b0,32'h0,         4'd0, 1'b0,1'b0,20'h0,     1'b0,4'd5, 4'd5, 1'b0,4'd0,  32'hDEADBEEF,  32'hDEADBEEF,  1'b0,1'b0,1'b0,20'h00003,32'd1};
    tv[5]  = '{1'b0,1'b1,32'h00001234,  4'd0, 1'b0,1'b0,20'h0,     1'b0,4'd0, 4'd0, 1'b0,4'd0,  32'h0,         32'h0,         1'b0,1'b0,1'b0,20'h00003,32'd2};
    tv[6]  = '{1'b0,1'b0,32'h0,         4'd0, 1'b0,1'b0,20'h0,     1'b0,4'd0, 4'd5, 1'b0,4'd0,  32'h0,         32'hDEADBEEF,  1'b0,1'b0,1'b0,20'h00003,32'd2};
    tv[7]  = '{1'b0,1'b0,32'h0,         4'd0, 1'b1,1'b0,20'h00002, 1'b0,4'd0, 4'd0, 1'b0,4'd0,  32'h0,         32'h0,         1'b0,1'b0,1'b1,20'h00002,32'd3};
    tv[8]  = '{1'b0,1'b0,32'h0,         4'd0, 1'b1,1'b1,20'hFFFFD, 1'b0,4'd0, 4'd0, 1'b0,4'd0,  32'h0,         32'h0,         1'b0,1'b0,1'b1,20'hFFFFF,32'd4};
    tv[9]  = '{1'b0,1'b0,32'h0,         4'd0, 1'b0,1'b0,20'h0,     1'b1,4'd0, 4'd0, 1'b0,4'd0,  32'h0,         32'h0,         1'b0,1'b0,1'b0,20'h00000,32'd4};
    tv[10] = '{1'b0,1'b0,32'h0,         4'd0, 1'b1,1'b0,20'h00100, 1'b1,4'd0, 4'd0, 1'b0,4'd0,  32'h0,         32'h0,         1'b0,1'b0,1'b1,20'h00100,32'd5};
    tv[11] = '{1'b0,1'b0,32'h0,         4'd0, 1'b0,1'b0,20'h0,     1'b0,4'd0, 4'd7, 1'b1,4'd7,  32'h0,         32'h0,         1'b0,1'b0,1'b0,20'h00100,32'd5};
    tv[12] = '{1'b0,1'b1,32'h00000077,  4'd7, 1'b0,1'b0,20'h0,     1'b0,4'd7, 4'd7, 1'b1,4'd7,  32'h00000077,  32'h00000077,  1'b1,1'b1,1'b0,20'h00100,32'd6};
    tv[13] = '{1'b0,1'b1,32'h00000078,  4'd7, 1'b0,1'b0,20'h0,     1'b0,4'd7, 4'd7, 1'b0,4'd0,  32'h00000078,  32'h00000078,  1'b1,1'b1,1'b0,20'h00100,32'd7};
    tv[14] = '{1'b0,1'b0,32'h0,         4'd0, 1'b0,1'b0,20'h0,     1'b0,4'd7, 4'd7, 1'b1,4'd0,  32'h00000078,  32'h00000078,  1'b0,1'b0,1'b0,20'h00100,32'd7};
    tv[15] = '{1'b0,1'b0,32'h0,         4'd0, 1'b0,1'b0,20'h0,     1'b0,4'd0, 4'd7, 1'b0,4'd0,  32'h0,         32'h00000078,  1'b0,1'b0,1'b0,20'h00100,32'd7};
    tv[16] = '{1'b0,1'b0,32'h0,         4'd0, 1'b0,1'b0,20'h0,     1'b0,4'd3, 4'd4, 1'b1,4'd3,  32'h0,         32'h0,         1'b0,1'b0,1'b0,20'h00100,32'd7};
    tv[17] = '{1'b0,1'b0,32'h0,         4'd0, 1'b0,1'b0,20'h0,     1'b0,4'd3, 4'd4, 1'b1,4'd4,  32'h0,         32'h0,         1'b1,1'b0,1'b0,20'h00100,32'd7};
    tv[18] = '{1'b0,1'b0,32'h0,         4'd0, 1'b0,1'b0,20'h0,     1'b0,4'd3, 4'd4, 1'b1,4'd9,  32'h0,         32'h0,         1'b1,1'b1,1'b0,20'h00100,32'd7};
    tv[19] = '{1'b0,1'b0,32'h0,         4'd0, 1'b1,1'b0,20'h00400, 1'b0,4'd9, 4'd11,1'b1,4'd11, 32'h0,         32'h0,         1'b1,1'b0,1'b1,20'h00400,32'd8};
    tv[20] = '{1'b0,1'b0,32'h0,         4'd0, 1'b0,1'b0,20'h0,     1'b0,4'd3, 4'd11,1'b0,4'd0,  32'h0,         32'h0,         1'b0,1'b0,1'b0,20'h00400,32'd8};
    tv[21] = '{1'b0,1'b1,32'h00000044,  4'd4, 1'b0,1'b0,20'h0,     1'b0,4'd4, 4'd9, 1'b0,4'd0,  32'h00000044,  32'h0,         1'b0,1'b0,1'b0,20'h00400,32'd9};
    tv[22] = '{1'b0,1'b0,32'h0,         4'd0, 1'b0,1'b0,20'h0,     1'b0,4'd4, 4'd4, 1'b0,4'd0,  32'h00000044,  32'h00000044,  1'b0,1'b0,1'b0,20'h00400,32'd9};
    tv[23] = '{1'b0,1'b1,32'h00000022,  4'd2, 1'b0,1'b0,20'h0,     1'b1,4'd0, 4'd0, 1'b1,4'd2,  32'h0,         32'h0,         1'b0,1'b0,1'b0,20'h00401,32'd10};
    tv[24] = '{1'b1,1'b1,32'h0000AAAA,  4'd2, 1'b1,1'b0,20'h00555, 1'b0,4'd2, 4'd2, 1'b1,4'd5,  32'h0000AAAA,  32'h0000AAAA,  1'b1,1'b1,1'b1,20'h00000,32'd0};
    tv[25] = '{1'b0,1'b0,32'h0,         4'd0, 1'b0,1'b0,20'h0,     1'b0,4'd2, 4'd5, 1'b0,4'd0,  32'h0,         32'h0,         1'b0,1'b0,1'b0,20'h00000,32'd0};
    tv[26] = '{1'b0,1'b0,32'h0,         4'd0, 1'b0,1'b0,20'h0,     1'b0,4'd4, 4'd0, 1'b0,4'd0,  32'h0,         32'h0,         1'b0,1'b0,1'b0,20'h00000,32'd0};

    idle();
    // reset, then sweep every read index for zero data and no pending bits
    @(negedge clk);
    rst_sync = 1'b1;
    @(posedge clk); #1;
    chk("reset pc_out", {12'h0, pc_out}, 32'h0);
    chk("reset retired", retired, 32'h0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      idle();
      rs1_index = 4'(i);
      rs2_index = 4'(15 - i);
      #1;
      chk($sformatf("reset rs1_data[%0d]", i), rs1_data, 32'h0);
      chk($sformatf("reset rs2_data[%0d]", 15 - i), rs2_data, 32'h0);
      chk($sformatf("reset rs1_pending[%0d]", i), {31'h0, rs1_pending}, 32'h0);
      chk($sformatf("reset rs2_pending[%0d]", 15 - i), {31'h0, rs2_pending}, 32'h0);
    end

    for (int v = 0; v < NV; v++) begin
      @(negedge clk);
      rst_sync = tv[v].rst; write_en = tv[v].we; write = tv[v].wd; write_index = tv[v].wi;
      write_pc_en = tv[v].pwe; pc_offset = tv[v].poff; pc = tv[v].pcv;
      fetch_advance = tv[v].fa; rs1_index = tv[v].r1; rs2_index = tv[v].r2;
      reserve_en = tv[v].re; reserve_index = tv[v].ri;
      #1;
      chk($sformatf("v%0d rs1_data", v), rs1_data, tv[v].e_r1d);
      chk($sformatf("v%0d rs2_data", v), rs2_data, tv[v].e_r2d);
      chk($sformatf("v%0d rs1_pending", v), {31'h0, rs1_pending}, {31'h0, tv[v].e_r1p});
      chk($sformatf("v%0d rs2_pending", v), {31'h0, rs2_pending}, {31'h0, tv[v].e_r2p});
      chk($sformatf("v%0d redirect", v), {31'h0, redirect}, {31'h0, tv[v].e_rd});
      @(posedge clk); #1;
      chk($sformatf("v%0d pc_out", v), {12'h0, pc_out}, {12'h0, tv[v].e_pc});
      chk($sformatf("v%0d retired", v), retired, tv[v].e_ret);
    end

    @(negedge clk);
    idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
